jtdd_pcm_mixer: RTL and testbench

- Parametrised, time-multiplexed N-channel PCM mixer; successor to the fixed 3-channel FM/ADPCM mix in the sound block.
- Sits between the sound generators (jt51 left/right, ADPCM channels) and the board audio output.
- On each sample strobe it snapshots all channels and gains, then runs one signed multiply-accumulate per clock.
- It then scales, saturates and registers the result, and reports overflow.

---
 rtl/jtdd_pcm_mixer.sv | 184 ++++++++++++++++++
 tb/tb_jtdd_pcm_mixer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_pcm_mixer.sv
// Time-multiplexed N-channel PCM mixer: one signed MAC per clock, then scale/saturate/register.
// Optional DC-blocking high-pass on the output when JTDD_MIX_DCBLOCK_EN is defined.
module jtdd_pcm_mixer #(
    parameter int unsigned CH   = 4,
    parameter int unsigned W    = 16,
    parameter int unsigned WOUT = 16,
    parameter int unsigned GW   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cen,
    input  logic [CH*W-1:0]        ch_in,
    input  logic [CH*GW-1:0]       gain,
    output logic signed [WOUT-1:0] mixed,
    output logic                   sample,
    output logic                   peak,
    output logic                   busy
);

    localparam int unsigned KW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned PW = W + GW + 1;
    localparam int unsigned AW = PW + $clog2(CH);
    localparam logic [KW-1:0]   KLAST = KW'(CH - 1);
    localparam logic [WOUT-1:0] OMAX  = {1'b0, {(WOUT-1){1'b1}}};
    localparam logic [WOUT-1:0] OMIN  = {1'b1, {(WOUT-1){1'b0}}};

`ifdef JTDD_MIX_DCBLOCK_EN
    typedef enum logic [2:0] {IDLE, MAC, SCALE, DCB, OUT} state_t;
`else
    typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;
`endif

    state_t                 state, state_nx;
    logic [KW-1:0]          k, k_nx;
    logic signed [AW-1:0]   acc, acc_nx;
    logic [CH*W-1:0]        ch_snap, ch_snap_nx;
    logic [CH*GW-1:0]       g_snap, g_snap_nx;
    logic signed [WOUT-1:0] mixed_nx;
    logic                   sample_nx, peak_nx, busy_nx;

    // Current channel selected from the snapshot by the channel counter
    logic signed [W-1:0]    cur_s;
    logic signed [GW:0]     cur_g;
    logic signed [PW-1:0]   prod;

    assign cur_s = ch_snap[k*W +: W];
    assign cur_g = {1'b0, g_snap[k*GW +: GW]};
    assign prod  = PW'(cur_s) * PW'(cur_g);

    // Gain has 4 fractional bits; arithmetic shift gives floor rounding
    logic signed [AW-1:0]   shifted;
    logic [AW-1:WOUT-1]     s_hi;
    logic                   s_clip;
    logic [WOUT-1:0]        s_sat;

    assign shifted = acc >>> 4;
    assign s_hi    = shifted[AW-1:WOUT-1];
    assign s_clip  = !((&s_hi) || !(|s_hi));
    assign s_sat   = s_clip ? (shifted[AW-1] ? OMIN : OMAX) : shifted[WOUT-1:0];

`ifdef JTDD_MIX_DCBLOCK_EN
    localparam int unsigned YW = WOUT + 10;

    logic signed [WOUT-1:0]   x_hold, x_hold_nx;
    logic                     clip_hold, clip_hold_nx;
    logic signed [WOUT-1:0]   x_prev, x_prev_nx;
    logic signed [WOUT+7:0]   y_state, y_state_nx;
    logic signed [YW-1:0]     dx, y_wide;
    logic [YW-1:WOUT+7]       y_hi;
    logic                     y_clip;
    logic signed [WOUT+7:0]   y_sat;

    // y_state keeps 8 fractional bits so the leak term keeps decaying small residues to zero
    assign dx     = YW'(x_hold) - YW'(x_prev);
    assign y_wide = (dx <<< 8) + YW'(y_state) - YW'(y_state >>> 8);
    assign y_hi   = y_wide[YW-1:WOUT+7];
    assign y_clip = !((&y_hi) || !(|y_hi));
    assign y_sat  = y_clip ? (y_wide[YW-1] ? {1'b1, {(WOUT+7){1'b0}}}
                                           : {1'b0, {(WOUT+7){1'b1}}})
                           : y_wide[WOUT+7:0];
`endif

    always_comb begin
        state_nx   = state;
        k_nx       = k;
        acc_nx     = acc;
        ch_snap_nx = ch_snap;
        g_snap_nx  = g_snap;
        mixed_nx   = mixed;
        sample_nx  = 1'b0;
        peak_nx    = peak;
        busy_nx    = busy;
`ifdef JTDD_MIX_DCBLOCK_EN
        x_hold_nx    = x_hold;
        clip_hold_nx = clip_hold;
        x_prev_nx    = x_prev;
        y_state_nx   = y_state;
`endif
        case (state)
            IDLE: begin
                if (cen) begin
                    ch_snap_nx = ch_in;
                    g_snap_nx  = gain;
                    acc_nx     = '0;
                    k_nx       = '0;
                    busy_nx    = 1'b1;
                    state_nx   = MAC;
                end
            end
            MAC: begin
                acc_nx = acc + AW'(prod);
                k_nx   = k + 1'b1;
                if (k == KLAST) state_nx = SCALE;
            end
            SCALE: begin
`ifdef JTDD_MIX_DCBLOCK_EN
                x_hold_nx    = s_sat;
                clip_hold_nx = s_clip;
                state_nx     = DCB;
`else
                mixed_nx  = s_sat;
                peak_nx   = s_clip;
                sample_nx = 1'b1;
                busy_nx   = 1'b0;
                state_nx  = OUT;
`endif
            end
`ifdef JTDD_MIX_DCBLOCK_EN
            DCB: begin
                mixed_nx   = y_sat[WOUT+7:8];
                peak_nx    = clip_hold | y_clip;
                sample_nx  = 1'b1;
                busy_nx    = 1'b0;
                x_prev_nx  = x_hold;
                y_state_nx = y_sat;
                state_nx   = OUT;
            end
`endif
            OUT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            k       <= '0;
            acc     <= '0;
            ch_snap <= '0;
            g_snap  <= '0;
            mixed   <= '0;
            sample  <= 1'b0;
            peak    <= 1'b0;
            busy    <= 1'b0;
`ifdef JTDD_MIX_DCBLOCK_EN
            x_hold    <= '0;
            clip_hold <= 1'b0;
            x_prev    <= '0;
            y_state   <= '0;
`endif
        end else begin
            state   <= state_nx;
            k       <= k_nx;
            acc     <= acc_nx;
            ch_snap <= ch_snap_nx;
            g_snap  <= g_snap_nx;
            mixed   <= mixed_nx;
            sample  <= sample_nx;
            peak    <= peak_nx;
            busy    <= busy_nx;
`ifdef JTDD_MIX_DCBLOCK_EN
            x_hold    <= x_hold_nx;
            clip_hold <= clip_hold_nx;
            x_prev    <= x_prev_nx;
            y_state   <= y_state_nx;
`endif
        end
    end

endmodule

// File: tb/tb_jtdd_pcm_mixer.sv
// Randomized self-checking bench for jtdd_pcm_mixer (default build) against an arithmetic reference model.
module tb_jtdd_pcm_mixer;

    localparam int CH   = 4;
    localparam int W    = 16;
    localparam int WOUT = 16;
    localparam int GW   = 8;
    localparam int LAT  = CH + 2;

    logic              clk;
    logic              rstn;
    logic              cen;
    logic [CH*W-1:0]   ch_in;
    logic [CH*GW-1:0]  gain;
    logic [WOUT-1:0]   mixed;
    logic              sample;
    logic              peak;
    logic              busy;

    int checks = 0;
    int errors = 0;

    jtdd_pcm_mixer #(.CH(CH), .W(W), .WOUT(WOUT), .GW(GW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .cen    (cen),
        .ch_in  (ch_in),
        .gain   (gain),
        .mixed  (mixed),
        .sample (sample),
        .peak   (peak),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: sum of sample*gain/16 with floor, clamped to the signed output range
    task automatic model(input logic [CH*W-1:0] c, input logic [CH*GW-1:0] g,
                         output logic [WOUT-1:0] m, output logic p);
        longint sum, q, omax, omin;
        logic [W-1:0]  s;
        logic [GW-1:0] gg;
        sum = 0;
        for (int i = 0; i < CH; i++) begin
            s   = c[i*W +: W];
            gg  = g[i*GW +: GW];
            sum = sum + longint'($signed(s)) * longint'(gg);
        end
        q = sum / 16;
        if ((sum % 16 != 0) && (sum < 0)) q = q - 1;
        omax = (longint'(1) << (WOUT-1)) - 1;
        omin = -omax - 1;
        if (q > omax) begin
            m = omax[WOUT-1:0];
            p = 1'b1;
        end else if (q < omin) begin
            m = omin[WOUT-1:0];
            p = 1'b1;
        end else begin
            m = q[WOUT-1:0];
            p = 1'b0;
        end
    endtask

    function automatic logic [CH*W-1:0] rand_ch();
        logic [CH*W-1:0] v;
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 4))
                0:       v[i*W +: W] = 16'h7FFF;
                1:       v[i*W +: W] = 16'h8000;
                2:       v[i*W +: W] = '0;
                3:       v[i*W +: W] = 16'($urandom_range(0, 63)) - 16'd32;
                default: v[i*W +: W] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    function automatic logic [CH*GW-1:0] rand_g();
        logic [CH*GW-1:0] v;
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 4))
                0:       v[i*GW +: GW] = 8'h00;
                1:       v[i*GW +: GW] = 8'hFF;
                2:       v[i*GW +: GW] = 8'h10;
                default: v[i*GW +: GW] = 8'($urandom);
            endcase
        end
        return v;
    endfunction

    // One full mix: checks latency, busy window, result, single pulse and hold
    task automatic do_mix(input string tag, input logic [CH*W-1:0] c,
                          input logic [CH*GW-1:0] g, input bit scramble);
        logic [WOUT-1:0] m_exp;
        logic            p_exp;
        bit              busy_ok;
        int              n;
        model(c, g, m_exp, p_exp);
        @(negedge clk);
        ch_in = c;
        gain  = g;
        cen   = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        busy_ok = 1'b1;
        n = 1;
        while (sample !== 1'b1 && n < LAT + 10) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (scramble) begin
                ch_in = rand_ch();
                gain  = rand_g();
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_busy_run"}, busy_ok, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_mixed"}, mixed, m_exp);
        check({tag, "_peak"}, peak, p_exp);
        @(negedge clk);
        check({tag, "_pulse"}, sample, 0);
        check({tag, "_hold"}, {peak, mixed}, {p_exp, m_exp});
    endtask

    initial begin
        logic [CH*W-1:0]  c;
        logic [CH*GW-1:0] g;
        logic [WOUT-1:0]  got;
        int               cnt;

        rstn  = 1'b0;
        cen   = 1'b0;
        ch_in = '0;
        gain  = '0;
        repeat (3) @(negedge clk);
        check("rst_mixed", mixed, 0);
        check("rst_flags", {sample, peak, busy}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        c = '0; g = '0; c[0 +: W] = 16'h1000; g[0 +: GW] = 8'h10;
        do_mix("unity", c, g, 0);
        c[0 +: W] = 16'h0003; g[0 +: GW] = 8'h08;
        do_mix("half_pos", c, g, 0);
        c[0 +: W] = 16'hFFFD;
        do_mix("half_neg", c, g, 0);
        c = {CH{16'h7FFF}}; g = {CH{8'hFF}};
        do_mix("sat_pos", c, g, 0);
        g = '0;
        do_mix("mute", c, g, 0);
        c = '0; g = '0;
        c[0 +: W] = 16'h8000; c[W +: W] = 16'h8000;
        g[0 +: GW] = 8'h10; g[GW +: GW] = 8'h10;
        do_mix("sat_neg", c, g, 0);

        // Second cen while busy must be dropped; result comes from the first snapshot
        c = '0; g = '0; c[0 +: W] = 16'h1000; g[0 +: GW] = 8'h10;
        @(negedge clk);
        ch_in = c; gain = g; cen = 1'b1;
        @(negedge clk);
        cen = 1'b0; ch_in[0 +: W] = 16'h2000;
        @(negedge clk);
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        cnt = 0;
        got = '0;
        repeat (30) begin
            if (sample === 1'b1) begin
                cnt++;
                got = mixed;
            end
            @(negedge clk);
        end
        check("dbl_count", cnt, 1);
        check("dbl_value", got, 16'h1000);

        // Leave a clipped result in place, then reset in the middle of the next mix
        c = {CH{16'h7FFF}}; g = {CH{8'hFF}};
        do_mix("pre_rst", c, g, 0);
        c = '0; g = '0; c[1 +: W] = 16'h0123; g[0 +: GW] = 8'h30;
        @(negedge clk);
        ch_in = c; gain = g; cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("amid_mixed", mixed, 0);
        check("amid_flags", {sample, peak, busy}, 0);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (sample === 1'b1) cnt++;
        end
        rstn = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (sample === 1'b1) cnt++;
        end
        check("amid_no_pulse", cnt, 0);
        check("amid_idle", {mixed, peak, busy}, 0);
        c = '0; g = '0; c[2*W +: W] = 16'hF000; g[2*GW +: GW] = 8'h20;
        do_mix("post_rst", c, g, 0);

        for (int i = 0; i < 60; i++) begin
            do_mix("rand", rand_ch(), rand_g(), i[0]);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
